fat32_volume_parser: RTL and testbench



---
 rtl/fat32_pkg.sv | 57 +++++
 rtl/sector_byte_counter.sv | 36 +++
 rtl/fat32_volume_parser.sv | 192 +++++++++++++++++++
 tb/tb_fat32_volume_parser.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fat32_pkg.sv
// Shared constants, state encoding and field helpers for the FAT32 volume parser.
// Optional superfloppy support is selected in the top by FAT32_SUPERFLOPPY_EN.
package fat32_pkg;

    localparam int unsigned MbrEntry0Off = 'h1BE;
    localparam int unsigned MbrTypeOff   = 4;
    localparam int unsigned MbrLbaOff    = 8;
    localparam int unsigned SigOff0      = 510;
    localparam int unsigned SigOff1      = 511;
    localparam logic [7:0]  SigByte0     = 8'h55;
    localparam logic [7:0]  SigByte1     = 8'hAA;

    localparam int unsigned BpbBpsOff    = 'h0B;
    localparam int unsigned BpbSpcOff    = 'h0D;
    localparam int unsigned BpbRsvdOff   = 'h0E;
    localparam int unsigned BpbNfatOff   = 'h10;
    localparam int unsigned BpbFatSzOff  = 'h24;
    localparam int unsigned BpbRootOff   = 'h2C;

    localparam logic [7:0] PartFat32Chs = 8'h0B;
    localparam logic [7:0] PartFat32Lba = 8'h0C;
    localparam logic [7:0] JmpShort     = 8'hEB;
    localparam logic [7:0] JmpNear      = 8'hE9;

    localparam logic [2:0] ErrNone     = 3'd0;
    localparam logic [2:0] ErrMbrSig   = 3'd1;
    localparam logic [2:0] ErrPartType = 3'd2;
    localparam logic [2:0] ErrBpbSig   = 3'd3;
    localparam logic [2:0] ErrBps      = 3'd4;
    localparam logic [2:0] ErrSpc      = 3'd5;
    localparam logic [2:0] ErrNumFats  = 3'd6;

    typedef enum logic [2:0] {
        StIdle, StReqMbr, StRdMbr, StReqBpb, StRdBpb, StCalc, StDone, StErr
    } state_e;

    // Replace the little-endian byte of w selected by idx if idx lies in [off, off+3].
    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [31:0] idx,
                                             input int unsigned off, input logic [7:0] b);
        logic [31:0] r;
        logic [1:0]  lane;
        r    = w;
        lane = 2'(idx - off);
        if (idx >= off && idx < off + 32'd4) r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

    function automatic logic [2:0] bpb_check(input logic sig_ok, input logic bps_ok,
                                             input logic [7:0] spc, input logic [7:0] nfat);
        if (!sig_ok) return ErrBpbSig;
        if (!bps_ok) return ErrBps;
        if (spc == 8'd0 || (spc & (spc - 8'd1)) != 8'd0) return ErrSpc;
        if (nfat == 8'd0) return ErrNumFats;
        return ErrNone;
    endfunction

endpackage

// File: rtl/sector_byte_counter.sv
// Byte position within the sector being streamed; clear has priority over increment.
module sector_byte_counter #(
    parameter int unsigned SECTOR_BYTES = 512,
    parameter int unsigned CntW         = $clog2(SECTOR_BYTES)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [CntW-1:0] cnt_o,
    output logic            last_o
);

    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == CntW'(SECTOR_BYTES - 1));

endmodule

// File: rtl/fat32_volume_parser.sv
// Reads MBR then FAT32 boot sector, validates both and derives FAT/data start sectors.
// Define FAT32_SUPERFLOPPY_EN to accept a boot sector directly at sector 0.
module fat32_volume_parser
    import fat32_pkg::*;
#(
    parameter int unsigned SECTOR_BYTES    = 512,
    parameter int unsigned PARTITION_INDEX = 0,
    parameter int unsigned SECTOR_WIDTH    = 32
) (
    input  logic                    Clock,
    input  logic                    sys_rst_n,
    input  logic                    Start,
    output logic                    ReadRequest,
    output logic [SECTOR_WIDTH-1:0] ReadSector,
    input  logic                    ByteValid,
    input  logic [7:0]              ByteIn,
    output logic                    Busy,
    output logic                    Ready,
    output logic                    Error,
    output logic [2:0]              ErrorCode,
    output logic [SECTOR_WIDTH-1:0] PartitionStart,
    output logic [SECTOR_WIDTH-1:0] FatStartSector,
    output logic [SECTOR_WIDTH-1:0] DataStartSector,
    output logic [SECTOR_WIDTH-1:0] RootCluster,
    output logic [7:0]              SectorsPerCluster
);

    localparam int unsigned CntW      = $clog2(SECTOR_BYTES);
    localparam int unsigned EntryBase = MbrEntry0Off + 16 * PARTITION_INDEX;

    state_e state_d, state_q;
    logic rd_req_d, rd_req_q, busy_d, busy_q, ready_d, ready_q, err_d, err_q, first_d, first_q;
    logic sig0_d, sig0_q;
    logic [2:0] code_d, code_q;
    logic [SECTOR_WIDTH-1:0] rd_sec_d, rd_sec_q, part_d, part_q, acc_d, acc_q;
    logic [SECTOR_WIDTH-1:0] o_part_d, o_part_q, o_fat_d, o_fat_q, o_data_d, o_data_q;
    logic [SECTOR_WIDTH-1:0] o_root_d, o_root_q;
    logic [7:0] o_spc_d, o_spc_q, ptype_d, ptype_q, spc_d, spc_q, nfat_d, nfat_q;
    logic [7:0] ccnt_d, ccnt_q;
    logic [15:0] bps_d, bps_q, rsvd_d, rsvd_q;
    logic [31:0] lba_d, lba_q, fatsz_d, fatsz_q, root_d, root_q, idx;
`ifdef FAT32_SUPERFLOPPY_EN
    logic jmp_d, jmp_q;
`endif

    logic [CntW-1:0] byte_idx;
    logic reading, accept, last_byte, sig_ok;
    logic [2:0] bpb_code;

    assign reading  = state_q inside {StReqMbr, StRdMbr, StReqBpb, StRdBpb};
    assign accept   = ByteValid && reading;
    assign idx      = 32'(byte_idx);
    assign sig_ok   = sig0_q && (ByteIn == SigByte1);
    assign bpb_code = bpb_check(sig_ok, bps_q == 16'(SECTOR_BYTES), spc_q, nfat_q);

    sector_byte_counter #(
        .SECTOR_BYTES(SECTOR_BYTES),
        .CntW        (CntW)
    ) u_byte_cnt (
        .clk_i (Clock),
        .rst_ni(sys_rst_n),
        .clr_i (!reading || (accept && last_byte)),
        .inc_i (accept),
        .cnt_o (byte_idx),
        .last_o(last_byte)
    );

    always_comb begin
        state_d = state_q; ready_d = ready_q; err_d = err_q; code_d = code_q;
        first_d = first_q; sig0_d = sig0_q; rd_sec_d = rd_sec_q; part_d = part_q;
        acc_d = acc_q; ccnt_d = ccnt_q; ptype_d = ptype_q; spc_d = spc_q; nfat_d = nfat_q;
        bps_d = bps_q; rsvd_d = rsvd_q; lba_d = lba_q; fatsz_d = fatsz_q; root_d = root_q;
        o_part_d = o_part_q; o_fat_d = o_fat_q; o_data_d = o_data_q;
        o_root_d = o_root_q; o_spc_d = o_spc_q;
`ifdef FAT32_SUPERFLOPPY_EN
        jmp_d = jmp_q;
`endif

        // MBR and BPB fields never overlap, so both sets are captured from every sector.
        if (accept) begin
            if (idx == SigOff0) sig0_d = (ByteIn == SigByte0);
            if (idx == EntryBase + MbrTypeOff) ptype_d = ByteIn;
            if (idx == BpbSpcOff) spc_d = ByteIn;
            if (idx == BpbNfatOff) nfat_d = ByteIn;
            lba_d   = put_byte(lba_q, idx, EntryBase + MbrLbaOff, ByteIn);
            fatsz_d = put_byte(fatsz_q, idx, BpbFatSzOff, ByteIn);
            root_d  = put_byte(root_q, idx, BpbRootOff, ByteIn);
            bps_d   = 16'(put_byte({16'd0, bps_q}, idx, BpbBpsOff, ByteIn));
            rsvd_d  = 16'(put_byte({16'd0, rsvd_q}, idx, BpbRsvdOff, ByteIn));
`ifdef FAT32_SUPERFLOPPY_EN
            if (idx == 0) jmp_d = (ByteIn == JmpShort) || (ByteIn == JmpNear);
`endif
        end

        case (state_q)
            StIdle, StDone, StErr: begin
                if (Start) begin
                    ready_d = 1'b0; err_d = 1'b0; code_d = ErrNone; rd_sec_d = '0;
                    o_part_d = '0; o_fat_d = '0; o_data_d = '0; o_root_d = '0; o_spc_d = '0;
                    state_d = StReqMbr;
                end
            end
            StReqMbr: if (ByteValid) state_d = StRdMbr;
            StReqBpb: if (ByteValid) state_d = StRdBpb;
            StRdMbr: begin
                if (accept && last_byte) begin
`ifdef FAT32_SUPERFLOPPY_EN
                    if (jmp_q && bps_q == 16'(SECTOR_BYTES)) begin
                        part_d = '0;
                        if (bpb_code != ErrNone) begin
                            err_d = 1'b1; code_d = bpb_code; state_d = StErr;
                        end else begin
                            first_d = 1'b1; state_d = StCalc;
                        end
                    end else
`endif
                    if (!sig_ok) begin
                        err_d = 1'b1; code_d = ErrMbrSig; state_d = StErr;
                    end else if (ptype_q != PartFat32Chs && ptype_q != PartFat32Lba) begin
                        err_d = 1'b1; code_d = ErrPartType; state_d = StErr;
                    end else begin
                        part_d = SECTOR_WIDTH'(lba_q); rd_sec_d = SECTOR_WIDTH'(lba_q);
                        state_d = StReqBpb;
                    end
                end
            end
            StRdBpb: begin
                if (accept && last_byte) begin
                    if (bpb_code != ErrNone) begin
                        err_d = 1'b1; code_d = bpb_code; state_d = StErr;
                    end else begin
                        first_d = 1'b1; state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                // Multiply FatSize*NumFATs by repeated addition, one FAT per cycle.
                if (first_q) begin
                    acc_d = part_q + SECTOR_WIDTH'(rsvd_q); ccnt_d = nfat_q; first_d = 1'b0;
                end else if (ccnt_q != 8'd0) begin
                    acc_d = acc_q + SECTOR_WIDTH'(fatsz_q); ccnt_d = ccnt_q - 8'd1;
                end else begin
                    o_part_d = part_q; o_fat_d = part_q + SECTOR_WIDTH'(rsvd_q);
                    o_data_d = acc_q; o_root_d = SECTOR_WIDTH'(root_q); o_spc_d = spc_q;
                    ready_d = 1'b1; state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        rd_req_d = state_d inside {StReqMbr, StReqBpb};
        busy_d   = !(state_d inside {StIdle, StDone, StErr});
    end

    always_ff @(posedge Clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle; rd_req_q <= 1'b0; busy_q <= 1'b0; ready_q <= 1'b0;
            err_q <= 1'b0; code_q <= '0; first_q <= 1'b0; sig0_q <= 1'b0;
            rd_sec_q <= '0; part_q <= '0; acc_q <= '0; ccnt_q <= '0;
            ptype_q <= '0; spc_q <= '0; nfat_q <= '0; bps_q <= '0; rsvd_q <= '0;
            lba_q <= '0; fatsz_q <= '0; root_q <= '0;
            o_part_q <= '0; o_fat_q <= '0; o_data_q <= '0; o_root_q <= '0; o_spc_q <= '0;
`ifdef FAT32_SUPERFLOPPY_EN
            jmp_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d; rd_req_q <= rd_req_d; busy_q <= busy_d; ready_q <= ready_d;
            err_q <= err_d; code_q <= code_d; first_q <= first_d; sig0_q <= sig0_d;
            rd_sec_q <= rd_sec_d; part_q <= part_d; acc_q <= acc_d; ccnt_q <= ccnt_d;
            ptype_q <= ptype_d; spc_q <= spc_d; nfat_q <= nfat_d; bps_q <= bps_d;
            rsvd_q <= rsvd_d; lba_q <= lba_d; fatsz_q <= fatsz_d; root_q <= root_d;
            o_part_q <= o_part_d; o_fat_q <= o_fat_d; o_data_q <= o_data_d;
            o_root_q <= o_root_d; o_spc_q <= o_spc_d;
`ifdef FAT32_SUPERFLOPPY_EN
            jmp_q <= jmp_d;
`endif
        end
    end

    assign ReadRequest       = rd_req_q;
    assign ReadSector        = rd_sec_q;
    assign Busy              = busy_q;
    assign Ready             = ready_q;
    assign Error             = err_q;
    assign ErrorCode         = code_q;
    assign PartitionStart    = o_part_q;
    assign FatStartSector    = o_fat_q;
    assign DataStartSector   = o_data_q;
    assign RootCluster       = o_root_q;
    assign SectorsPerCluster = o_spc_q;

endmodule

// File: tb/tb_fat32_volume_parser.sv
// Directed table-driven bench for fat32_volume_parser, plus reset/restart/superfloppy sequences.
module tb_fat32_volume_parser;
    import fat32_pkg::*;

    localparam int unsigned SW = 32;

    logic          Clock = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          Start = 1'b0;
    logic          ByteValid = 1'b0;
    logic [7:0]    ByteIn = 8'd0;
    logic          ReadRequest, Busy, Ready, Error;
    logic [SW-1:0] ReadSector, PartitionStart, FatStartSector, DataStartSector, RootCluster;
    logic [2:0]    ErrorCode;
    logic [7:0]    SectorsPerCluster;

    fat32_volume_parser #(
        .SECTOR_BYTES   (512),
        .PARTITION_INDEX(0),
        .SECTOR_WIDTH   (SW)
    ) dut (
        .Clock            (Clock),
        .sys_rst_n        (sys_rst_n),
        .Start            (Start),
        .ReadRequest      (ReadRequest),
        .ReadSector       (ReadSector),
        .ByteValid        (ByteValid),
        .ByteIn           (ByteIn),
        .Busy             (Busy),
        .Ready            (Ready),
        .Error            (Error),
        .ErrorCode        (ErrorCode),
        .PartitionStart   (PartitionStart),
        .FatStartSector   (FatStartSector),
        .DataStartSector  (DataStartSector),
        .RootCluster      (RootCluster),
        .SectorsPerCluster(SectorsPerCluster)
    );

    always #5 Clock = ~Clock;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    req_rises = 0;
    logic  req_prev = 1'b0;
    string tag = "reset";
    logic [7:0] sec [512];

    always @(posedge Clock) begin
        req_prev <= ReadRequest;
        if (ReadRequest && !req_prev) req_rises <= req_rises + 1;
    end

    typedef struct {
        string      name;
        logic [7:0] mbr_sig1;
        logic [7:0] ptype;
        logic [7:0] bpb_sig1;
        logic [15:0] bps;
        logic [7:0] spc;
        logic [7:0] nfat;
        logic [2:0] code;
        logic [31:0] data;
    } vec_t;

    vec_t tbl [10];

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got 0x%0h, want 0x%0h", tag, name, act, exp);
        end
    endtask

    task automatic put32(input int off, input logic [31:0] v);
        for (int i = 0; i < 4; i++) sec[off + i] = v[8*i +: 8];
    endtask

    task automatic mk_mbr(input logic [7:0] ptype, input logic [31:0] lba, input logic [7:0] s1);
        for (int i = 0; i < 512; i++) sec[i] = 8'h00;
        sec['h1BE + 4] = ptype;
        put32('h1C6, lba);
        sec[510] = 8'h55;
        sec[511] = s1;
    endtask

    task automatic mk_bpb(input logic [15:0] bps, input logic [7:0] spc, input logic [15:0] rsvd,
                          input logic [7:0] nfat, input logic [31:0] fatsz,
                          input logic [31:0] root, input logic [7:0] s1);
        for (int i = 0; i < 512; i++) sec[i] = 8'h00;
        sec[0]  = 8'hEB;
        sec[11] = bps[7:0];
        sec[12] = bps[15:8];
        sec[13] = spc;
        sec[14] = rsvd[7:0];
        sec[15] = rsvd[15:8];
        sec[16] = nfat;
        put32('h24, fatsz);
        put32('h2C, root);
        sec[510] = 8'h55;
        sec[511] = s1;
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            ByteValid = 1'b1;
            ByteIn    = sec[i];
            tick();
        end
        ByteValid = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!ReadRequest && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", ReadRequest, 1'b1);
    endtask

    task automatic run_vec(input vec_t v);
        int   n, base;
        logic ok;
        tag  = v.name;
        ok   = (v.code == ErrNone);
        base = req_rises;
        mk_mbr(v.ptype, 32'h2000, v.mbr_sig1);
        pulse_start();
        wait_req();
        chk("rdsec_mbr", ReadSector, 32'h0);
        feed(512);
        if (ReadRequest) begin
            chk("rdsec_bpb", ReadSector, 32'h2000);
            mk_bpb(v.bps, v.spc, 16'd32, v.nfat, 32'd961, 32'd2, v.bpb_sig1);
            feed(512);
        end
        n = 0;
        while (!Ready && !Error && n < 100) begin
            tick();
            n++;
        end
        if (ok) chk("latency", n, 32'(v.nfat) + 2);
        repeat (4) tick();
        chk("ready", Ready, ok);
        chk("error", Error, !ok);
        chk("code", ErrorCode, v.code);
        chk("reads", req_rises - base, (v.code == ErrMbrSig || v.code == ErrPartType) ? 1 : 2);
        chk("part", PartitionStart, ok ? 32'h2000 : 32'h0);
        chk("fat", FatStartSector, ok ? 32'h2020 : 32'h0);
        chk("data", DataStartSector, v.data);
        chk("root", RootCluster, ok ? 32'd2 : 32'd0);
        chk("spc", SectorsPerCluster, ok ? v.spc : 8'd0);
        chk("busy", Busy, 1'b0);
    endtask

    task automatic chk_all_zero();
        chk("z_req", ReadRequest, 1'b0);
        chk("z_rdsec", ReadSector, 32'h0);
        chk("z_busy", Busy, 1'b0);
        chk("z_ready", Ready, 1'b0);
        chk("z_error", Error, 1'b0);
        chk("z_code", ErrorCode, 3'd0);
        chk("z_part", PartitionStart, 32'h0);
        chk("z_fat", FatStartSector, 32'h0);
        chk("z_data", DataStartSector, 32'h0);
        chk("z_root", RootCluster, 32'h0);
        chk("z_spc", SectorsPerCluster, 8'h0);
        chk("z_state", dut.state_q, StIdle);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{"nominal",  8'hAA, 8'h0C, 8'hAA, 16'd512,  8'd8,  8'd2, 3'd0, 32'h27A2};
        tbl[1] = '{"type07",   8'hAA, 8'h07, 8'hAA, 16'd512,  8'd8,  8'd2, 3'd2, 32'h0};
        tbl[2] = '{"bpbsig",   8'hAA, 8'h0C, 8'h00, 16'd512,  8'd8,  8'd2, 3'd3, 32'h0};
        tbl[3] = '{"restart",  8'hAA, 8'h0B, 8'hAA, 16'd512,  8'd1,  8'd1, 3'd0, 32'h23E1};
        tbl[4] = '{"mbrsig",   8'h00, 8'h0C, 8'hAA, 16'd512,  8'd8,  8'd2, 3'd1, 32'h0};
        tbl[5] = '{"bps1024",  8'hAA, 8'h0C, 8'hAA, 16'd1024, 8'd8,  8'd2, 3'd4, 32'h0};
        tbl[6] = '{"spc6",     8'hAA, 8'h0C, 8'hAA, 16'd512,  8'd6,  8'd2, 3'd5, 32'h0};
        tbl[7] = '{"nfat0",    8'hAA, 8'h0C, 8'hAA, 16'd512,  8'd8,  8'd0, 3'd6, 32'h0};
        tbl[8] = '{"spc0nf0",  8'hAA, 8'h0C, 8'hAA, 16'd512,  8'd0,  8'd0, 3'd5, 32'h0};
        tbl[9] = '{"threefat", 8'hAA, 8'h0C, 8'hAA, 16'd512,  8'd64, 8'd3, 3'd0, 32'h2B63};

        repeat (3) tick();
        chk_all_zero();
        sys_rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        tag = "start_clears";
        pulse_start();
        chk("ready", Ready, 1'b0);
        chk("data", DataStartSector, 32'h0);
        chk("busy", Busy, 1'b1);

        tag = "reset_mid";
        mk_mbr(8'h0C, 32'h2000, 8'hAA);
        wait_req();
        feed(512);
        chk("rdsec_bpb", ReadSector, 32'h2000);
        mk_bpb(16'd512, 8'd8, 16'd32, 8'd2, 32'd961, 32'd2, 8'hAA);
        feed(200);
        ByteValid = 1'b1;
        ByteIn    = sec[200];
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk_all_zero();
        ByteValid = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        tick();

        tag = "idle_bytes";
        for (int i = 0; i < 5; i++) begin
            ByteValid = 1'b1;
            ByteIn    = 8'hEB;
            tick();
        end
        ByteValid = 1'b0;
        chk("busy", Busy, 1'b0);
        run_vec(tbl[0]);

        run_vec(tbl[1]);
        tag = "err_clear";
        pulse_start();
        chk("error", Error, 1'b0);
        chk("code", ErrorCode, 3'd0);

`ifdef FAT32_SUPERFLOPPY_EN
        begin
            int n, base;
            tag  = "superfloppy";
            base = req_rises - 1;
            mk_bpb(16'd512, 8'd8, 16'd32, 8'd2, 32'd100, 32'd2, 8'hAA);
            wait_req();
            feed(512);
            n = 0;
            while (!Ready && !Error && n < 100) begin
                tick();
                n++;
            end
            chk("latency", n, 4);
            repeat (4) tick();
            chk("ready", Ready, 1'b1);
            chk("part", PartitionStart, 32'd0);
            chk("fat", FatStartSector, 32'd32);
            chk("data", DataStartSector, 32'd232);
            chk("reads", req_rises - base, 1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
